// File: rtl/ws2812_decoder_pkg.sv
// Shared types and helpers for the WS2812 receive path.
package ws2812_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } ws2812_rx_state_t;

    typedef logic [23:0] ws2812_pixel_t;

    // Whole clk cycles in a duration given in ns, rounded down.
    function automatic logic [63:0] ns_to_cycles(input logic [63:0] freq, input logic [63:0] ns);
        return (freq * ns) / 64'd1_000_000_000;
    endfunction

endpackage

// File: rtl/ws2812_decoder_if.sv
// Pixel output port of the WS2812 decoder.
// A pixel moves on every clock edge where pixel_valid && pixel_ready; while valid is high and
// ready is low, pixel_data and pixel_index hold steady and valid never drops.
interface ws2812_decoder_if
    import ws2812_pkg::*;
#(
    parameter int unsigned IW = 8
) ();
    logic          pixel_valid;
    logic          pixel_ready;
    ws2812_pixel_t pixel_data;
    logic [IW-1:0] pixel_index;

    modport master (output pixel_valid, output pixel_data, output pixel_index, input pixel_ready);
    modport slave  (input pixel_valid, input pixel_data, input pixel_index, output pixel_ready);
endinterface

// File: rtl/ws2812_decoder_pulse_timer.sv
// ws2812_pulse_timer: 2-FF synchroniser, edge detect and saturating high/low run counters.
// The synchronised level is exported only when WS2812_DECODER_PASSTHRU_EN is defined.
module ws2812_pulse_timer #(
    parameter int unsigned   CW      = 11,
    parameter logic [CW-1:0] C_RESET = 11'd1350
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_din,
    output logic          o_rise,
    output logic          o_fall,
    output logic [CW-1:0] o_hc,
    output logic          o_low_timeout
`ifdef WS2812_DECODER_PASSTHRU_EN
    ,
    output logic          o_din_s
`endif
);
    logic [1:0]    r_sync;
    logic          r_prev;
    logic [CW-1:0] r_hc;
    logic [CW-1:0] r_lc;
    logic          w_din_s;

    assign w_din_s = r_sync[1];

    // On the cycle a falling edge is seen, r_hc holds the number of high samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b00;
            r_prev <= 1'b0;
            r_hc   <= '0;
            r_lc   <= '0;
        end else begin
            r_sync <= {r_sync[0], i_din};
            r_prev <= w_din_s;
            if (w_din_s) begin
                r_lc <= '0;
                if (r_hc != C_RESET) r_hc <= r_hc + CW'(1);
            end else begin
                r_hc <= '0;
                if (r_lc != C_RESET) r_lc <= r_lc + CW'(1);
            end
        end
    end

    assign o_rise        = w_din_s & ~r_prev;
    assign o_fall        = ~w_din_s & r_prev;
    assign o_hc          = r_hc;
    assign o_low_timeout = (r_lc == C_RESET);
`ifdef WS2812_DECODER_PASSTHRU_EN
    assign o_din_s       = w_din_s;
`endif
endmodule

// File: rtl/ws2812_decoder.sv
// ws2812_decoder: WS2812 bit decoder, pixel assembler and valid/ready output register.
// Optional chain pass-through on dout is built when WS2812_DECODER_PASSTHRU_EN is defined.
module ws2812_decoder
    import ws2812_pkg::*;
#(
    parameter longint unsigned FREQ        = 27_000_000,
    parameter longint unsigned T_BIT1_NS   = 600,
    parameter longint unsigned T_GLITCH_NS = 100,
    parameter longint unsigned T_RESET_NS  = 50_000,
    parameter int unsigned     MAX_PIXELS  = 256
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                din,
    input  logic                clear_status,
    ws2812_decoder_if.master    pix,
    output logic                frame_end,
    output logic                err_glitch,
    output logic                err_overflow,
    output logic                err_long,
    output logic                dout,
    output ws2812_rx_state_t    o_dbg_state
);
    localparam logic [63:0]    C_BIT1    = ns_to_cycles(FREQ, T_BIT1_NS);
    localparam logic [63:0]    C_GLITCH  = ns_to_cycles(FREQ, T_GLITCH_NS);
    localparam logic [63:0]    C_RESET   = ns_to_cycles(FREQ, T_RESET_NS);
    localparam int unsigned    CW        = $clog2(C_RESET + 64'd1);
    localparam int unsigned    IW        = $clog2(MAX_PIXELS);
    localparam logic [CW-1:0]  C_BIT1_W  = CW'(C_BIT1);
    localparam logic [CW-1:0]  C_GLIT_W  = CW'(C_GLITCH);
    localparam logic [CW-1:0]  C_RESET_W = CW'(C_RESET);
    localparam logic [IW:0]    C_MAX     = (IW+1)'(MAX_PIXELS);

    logic             w_rise, w_fall, w_low_to;
    logic [CW-1:0]    w_hc;
    ws2812_rx_state_t r_state, w_next;
    logic             w_bit_ev, w_bit_val, w_glitch_set, w_latch, w_frame_end;
    ws2812_pixel_t    r_shift, r_data;
    logic [4:0]       r_bit_cnt;
    logic             r_complete, r_seen, r_valid;
    logic [IW:0]      r_idx;
    logic [IW-1:0]    r_index;
    logic             w_busy, w_room, w_load;

`ifdef WS2812_DECODER_PASSTHRU_EN
    logic w_din_s;
`endif

    ws2812_pulse_timer #(.CW(CW), .C_RESET(C_RESET_W)) u_timer (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_din         (din),
        .o_rise        (w_rise),
        .o_fall        (w_fall),
        .o_hc          (w_hc),
        .o_low_timeout (w_low_to)
`ifdef WS2812_DECODER_PASSTHRU_EN
        ,
        .o_din_s       (w_din_s)
`endif
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= SYNC;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_bit_ev     = 1'b0;
        w_bit_val    = 1'b0;
        w_glitch_set = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            SYNC: if (w_low_to) w_next = IDLE;
            IDLE: if (w_rise) w_next = HIGH;
            HIGH: begin
                if (w_fall) begin
                    w_next = LOW;
                    if (w_hc < C_GLIT_W) begin
                        w_glitch_set = 1'b1;
                    end else begin
                        w_bit_ev  = 1'b1;
                        w_bit_val = (w_hc >= C_BIT1_W);
                    end
                end else if (w_hc == C_RESET_W) begin
                    // Line stuck high: alignment is lost, resynchronise on the next long low.
                    w_next       = SYNC;
                    w_glitch_set = 1'b1;
                end
            end
            LOW: begin
                if (w_low_to) begin
                    w_latch = 1'b1;
                    w_next  = IDLE;
                end
                if (w_rise) w_next = HIGH;
            end
            default: w_next = SYNC;
        endcase
    end

    assign w_frame_end = w_latch & r_seen;

    // Bit shifter and frame position; a latch or resync discards any partial pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_complete <= 1'b0;
            r_seen     <= 1'b0;
            r_idx      <= '0;
        end else begin
            r_complete <= w_bit_ev && (r_bit_cnt == 5'd23);
            if (r_complete && (r_idx != C_MAX)) r_idx <= r_idx + (IW+1)'(1);
            if (w_bit_ev) begin
                r_shift   <= {r_shift[22:0], w_bit_val};
                r_seen    <= 1'b1;
                r_bit_cnt <= (r_bit_cnt == 5'd23) ? 5'd0 : r_bit_cnt + 5'd1;
            end
            if ((r_state == SYNC) || w_latch) begin
                r_bit_cnt <= '0;
                r_seen    <= 1'b0;
                r_idx     <= '0;
            end
        end
    end

    assign w_busy = r_valid & ~pix.pixel_ready;
    assign w_room = (r_idx < C_MAX);
    assign w_load = r_complete & w_room & ~w_busy;

    // Output register and sticky flags; a set event beats a coincident clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_index      <= '0;
            frame_end    <= 1'b0;
            err_glitch   <= 1'b0;
            err_overflow <= 1'b0;
            err_long     <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= r_shift;
                r_index <= r_idx[IW-1:0];
            end else if (r_valid && pix.pixel_ready) begin
                r_valid <= 1'b0;
            end
            frame_end    <= w_frame_end;
            err_glitch   <= (err_glitch & ~clear_status) | w_glitch_set;
            err_overflow <= (err_overflow & ~clear_status) | (r_complete & w_busy);
            err_long     <= (err_long & ~clear_status) | (r_complete & ~w_room);
        end
    end

    assign pix.pixel_valid = r_valid;
    assign pix.pixel_data  = r_data;
    assign pix.pixel_index = r_index;
    assign o_dbg_state     = r_state;

`ifdef WS2812_DECODER_PASSTHRU_EN
    logic r_pt_en, r_dout;

    // After pixel 0 is consumed, the rest of the frame is forwarded down the chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pt_en <= 1'b0;
            r_dout  <= 1'b0;
        end else begin
            if (w_latch || (r_state == SYNC)) r_pt_en <= 1'b0;
            else if (r_complete && (r_idx == '0)) r_pt_en <= 1'b1;
            r_dout <= (r_pt_en && !w_frame_end) ? w_din_s : 1'b0;
        end
    end

    assign dout = r_dout;
`else
    assign dout = 1'b0;
`endif
endmodule
